dbg_bus_master: RTL and testbench
=================================

Name: dbg_bus_master

Overview:
- Byte-stream debug loader that acts as an initiator on the picorv32-style native memory bus (valid/ready, addr, wdata, wstrb, rdata).
- Receives command bytes from the UART receive path and issues single-word reads/writes to RAM or I/O.
- Returns response bytes to the UART transmit path.
- Sits beside the CPU in front of the system address decoder; the bus arbiter grants it the bus while cpu_hold is high.

Parameters:
- BUS_TIMEOUT, 1024: max cycles mem_valid may wait for mem_ready before abort.
- RX_TIMEOUT, 50000: max idle cycles between bytes of one command before the parser resets.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_resetn  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle pulse, rx_data valid.
- tx_data  out  8  response byte.
- tx_valid  out  1  response byte valid.
- tx_ready  in  1  transmitter accepts byte when tx_valid&tx_ready.
- mem_valid  out  1  bus request.
- mem_addr  out  32  word-aligned byte address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  byte strobes; 4'hF for write, 4'h0 for read.
- mem_ready  in  1  one-cycle transaction acknowledge.
- mem_rdata  in  32  read data, valid when mem_ready=1.
- cpu_hold  out  1  high from first command byte until response fully sent.
- rx_overrun  out  1  sticky: byte received while not in IDLE/ADDR/DATA.

Behaviour:
- Reset: all outputs 0, state IDLE, address/data shift registers 0, counters 0.
- Commands:
  - 0x57 'W' + 4 address bytes + 4 data bytes, each MSB first -> write; response 0x4B.
  - 0x52 'R' + 4 address bytes -> read; response 4 data bytes, MSB first.
  - Any other byte in IDLE is ignored, with no response.
- States:
  - IDLE -> ADDR on 'W'/'R'; cpu_hold set.
  - ADDR: shift 4 bytes in; -> DATA (write) or BUS (read).
  - DATA: shift 4 bytes in; -> BUS.
  - BUS: mem_valid=1 with addr/wdata/wstrb stable; -> RESP.
  - RESP: send bytes; -> IDLE, clearing cpu_hold.
- Latency: mem_valid rises the cycle after the rx_valid of the last command byte.
- mem_addr[1:0] is forced to 00; address bits [1:0] from the host are discarded.
- Bus handshake:
  - mem_ready is sampled each cycle while mem_valid=1.
  - On mem_ready=1, mem_rdata is captured and mem_valid drops the next cycle.
  - mem_ready seen while mem_valid=0 is ignored.
- Bus timeout: a BUS cycle counter counts from mem_valid rise. At BUS_TIMEOUT cycles without mem_ready:
  - mem_valid drops;
  - response is single byte 0x45 'E' for both reads and writes.
- Parser timeout: an inter-byte counter runs in ADDR/DATA and restarts on each rx_valid. Reaching RX_TIMEOUT -> IDLE, cpu_hold cleared, no response, no bus cycle.
- Response handshake: tx_valid/tx_data are held until tx_ready=1. The next byte may be presented the following cycle. tx_ready while tx_valid=0 is ignored.
- rx_valid in BUS or RESP: byte dropped, rx_overrun set. rx_overrun clears only on reset.
- Reset mid-transaction: mem_valid and tx_valid drop immediately (async); a partially sent response is lost.

Optional Feature:
- DBG_AUTOINC_EN defined:
  - Internal pointer loaded with the address of each 'W'/'R' and incremented by 4 after each successful bus cycle; wraps 0xFFFFFFFC -> 0x00000000.
  - Commands 0x77 'w' (+4 data bytes) and 0x72 'r' (no payload) use the pointer and skip ADDR. Responses are the same as 'W'/'R'.
  - On bus timeout the pointer is not incremented.
- DBG_AUTOINC_EN undefined: 'w'/'r' are ignored like any unknown byte; no pointer logic exists.

Test Plan:
- Write: send 57 00 00 01 04 DE AD BE EF; responder acks after 2 cycles -> one cycle with mem_addr=0x00000104, wdata=0xDEADBEEF, wstrb=F; response 0x4B; cpu_hold low afterwards.
- Read: send 52 00 00 80 04; responder returns 0x000000A5 -> mem_addr=0x00008004, wstrb=0; tx bytes 00 00 00 A5 in order, with tx_ready stalled 3 cycles per byte.
- Bus timeout with BUS_TIMEOUT=16: read to 0x00009000, mem_ready never asserted -> mem_valid low after 16 cycles; single response 0x45.
- Parser timeout with RX_TIMEOUT=100: send 57 00 00 then silence 100 cycles -> IDLE, no mem_valid, cpu_hold low; then a full read command works normally.
- Overrun and misalignment: read address 0x00000107 -> mem_addr=0x00000104; inject a byte during RESP -> rx_overrun=1, response unchanged.
- DBG_AUTOINC_EN: W to 0x00000FFC, then 'w' 11223344, then 'r' -> writes at 0xFFC and 0x1000; read at 0x1004; three correct responses.

Source files
------------

// File: rtl/dbg_bus_master.sv
// dbg_bus_master: UART byte-stream debug loader, single-word
// initiator on a native valid/ready memory bus.
//
// Ports
//   sys_clk, sys_resetn   clock, async active-low reset
//   rx_data/rx_valid      command bytes from the UART receiver
//   tx_data/tx_valid/     response bytes to the UART transmitter
//   tx_ready
//   mem_*                 native bus initiator (valid/ready, addr,
//                         wdata, wstrb, rdata)
//   cpu_hold              bus grant request while a command runs
//   rx_overrun            sticky: byte dropped during BUS/RESP
//
// Commands: 'W' a3 a2 a1 a0 d3 d2 d1 d0 -> 'K'
//           'R' a3 a2 a1 a0             -> d3 d2 d1 d0
//           bus timeout on either       -> 'E'
//
// Optional build macro DBG_AUTOINC_EN adds an auto-incrementing
// address pointer and the short commands 'w' (+4 data) / 'r'.

module dbg_bus_master #(
  parameter int BUS_TIMEOUT = 1024,
  parameter int RX_TIMEOUT  = 50000
) (
  input  logic        sys_clk,
  input  logic        sys_resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        cpu_hold,
  output logic        rx_overrun
);

  localparam int BCW = $clog2(BUS_TIMEOUT + 1);
  localparam int RCW = $clog2(RX_TIMEOUT + 1);

  localparam logic [BCW-1:0] BUS_LAST = BCW'(BUS_TIMEOUT - 1);
  localparam logic [BCW-1:0] BUS_ONE  = BCW'(1);
  localparam logic [RCW-1:0] RX_LAST  = RCW'(RX_TIMEOUT - 1);
  localparam logic [RCW-1:0] RX_ONE   = RCW'(1);

  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] CMD_R   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic           wr_q, wr_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    data_q, data_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;
  logic [BCW-1:0] bus_cnt_q, bus_cnt_d;
  logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_valid_q, tx_valid_d;
  logic [1:0]     resp_left_q, resp_left_d;
  logic           overrun_q, overrun_d;
  logic           hold_q, hold_d;
  logic           mem_valid_q, mem_valid_d;

`ifdef DBG_AUTOINC_EN
  localparam logic [7:0] CMD_WI = 8'h77;
  localparam logic [7:0] CMD_RI = 8'h72;

  logic [31:0]    ptr_q, ptr_d;
`endif

  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      byte_cnt_q  <= '0;
      bus_cnt_q   <= '0;
      rx_cnt_q    <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      resp_left_q <= '0;
      overrun_q   <= 1'b0;
      hold_q      <= 1'b0;
      mem_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      byte_cnt_q  <= byte_cnt_d;
      bus_cnt_q   <= bus_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      resp_left_q <= resp_left_d;
      overrun_q   <= overrun_d;
      hold_q      <= hold_d;
      mem_valid_q <= mem_valid_d;
    end
  end

`ifdef DBG_AUTOINC_EN
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    byte_cnt_d  = byte_cnt_q;
    bus_cnt_d   = bus_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    resp_left_d = resp_left_q;
    overrun_d   = overrun_q;
    hold_d      = hold_q;
    mem_valid_d = mem_valid_q;
`ifdef DBG_AUTOINC_EN
    ptr_d       = ptr_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          unique case (rx_data)
            CMD_W, CMD_R: begin
              wr_d       = (rx_data == CMD_W);
              hold_d     = 1'b1;
              byte_cnt_d = '0;
              rx_cnt_d   = '0;
              state_d    = S_ADDR;
            end
`ifdef DBG_AUTOINC_EN
            // Short forms reuse the pointer and skip address bytes.
            CMD_WI: begin
              wr_d       = 1'b1;
              hold_d     = 1'b1;
              addr_d     = ptr_q;
              byte_cnt_d = '0;
              rx_cnt_d   = '0;
              state_d    = S_DATA;
            end
            CMD_RI: begin
              wr_d        = 1'b0;
              hold_d      = 1'b1;
              addr_d      = ptr_q;
              bus_cnt_d   = '0;
              mem_valid_d = 1'b1;
              state_d     = S_BUS;
            end
`endif
            default: ;
          endcase
        end
      end

      S_ADDR: begin
        if (rx_valid) begin
          addr_d     = {addr_q[23:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          rx_cnt_d   = '0;
          if (byte_cnt_q == 2'd3) begin
`ifdef DBG_AUTOINC_EN
            ptr_d = {addr_d[31:2], 2'b00};
`endif
            if (wr_q) begin
              state_d = S_DATA;
            end else begin
              bus_cnt_d   = '0;
              mem_valid_d = 1'b1;
              state_d     = S_BUS;
            end
          end
        end else if (rx_cnt_q == RX_LAST) begin
          hold_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + RX_ONE;
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          data_d     = {data_q[23:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          rx_cnt_d   = '0;
          if (byte_cnt_q == 2'd3) begin
            bus_cnt_d   = '0;
            mem_valid_d = 1'b1;
            state_d     = S_BUS;
          end
        end else if (rx_cnt_q == RX_LAST) begin
          hold_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + RX_ONE;
        end
      end

      S_BUS: begin
        if (rx_valid) begin
          overrun_d = 1'b1;
        end
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          tx_valid_d  = 1'b1;
          state_d     = S_RESP;
`ifdef DBG_AUTOINC_EN
          ptr_d       = ptr_q + 32'd4;
`endif
          if (wr_q) begin
            tx_data_d   = RSP_ACK;
            resp_left_d = 2'd0;
          end else begin
            // Byte 3 goes out now; the rest queue up MSB first.
            tx_data_d   = mem_rdata[31:24];
            data_d      = {mem_rdata[23:0], 8'h00};
            resp_left_d = 2'd3;
          end
        end else if (bus_cnt_q == BUS_LAST) begin
          mem_valid_d = 1'b0;
          tx_valid_d  = 1'b1;
          tx_data_d   = RSP_ERR;
          resp_left_d = 2'd0;
          state_d     = S_RESP;
        end else begin
          bus_cnt_d = bus_cnt_q + BUS_ONE;
        end
      end

      S_RESP: begin
        if (rx_valid) begin
          overrun_d = 1'b1;
        end
        if (tx_valid_q && tx_ready) begin
          if (resp_left_q != 2'd0) begin
            tx_data_d   = data_q[31:24];
            data_d      = {data_q[23:0], 8'h00};
            resp_left_d = resp_left_q - 2'd1;
          end else begin
            tx_valid_d = 1'b0;
            hold_d     = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign mem_valid  = mem_valid_q;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = data_q;
  assign mem_wstrb  = (mem_valid_q && wr_q) ? 4'hF : 4'h0;
  assign cpu_hold   = hold_q;
  assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_dbg_bus_master.sv
// tb_dbg_bus_master: directed + randomized bench for dbg_bus_master
// with a bus responder, a UART tx sink and a word-memory model.

module tb_dbg_bus_master;

  localparam int BUS_TO = 16;
  localparam int RX_TO  = 100;

`ifdef DBG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_resetn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        cpu_hold;
  logic        rx_overrun;

  dbg_bus_master #(
    .BUS_TIMEOUT(BUS_TO),
    .RX_TIMEOUT (RX_TO)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_resetn(sys_resetn),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .cpu_hold  (cpu_hold),
    .rx_overrun(rx_overrun)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } txn_t;

  int tests = 0;
  int fails = 0;

  txn_t       busq[$];
  logic [7:0] txq[$];
  logic [31:0] dev_mem [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] ptr = 32'h0;

  int   ack_delay = 0;
  int   tx_stall = 0;
  int   vcnt = 0;
  int   last_len = 0;
  int   scnt = 0;
  int   stab_err = 0;
  txn_t cur;
  logic [7:0] tcap;

  function automatic logic [31:0] dflt(input logic [29:0] w);
    return {2'b00, w} ^ 32'h5A5A_3C3C;
  endfunction

  // Bus responder: logs each request, acks after ack_delay cycles
  // (never when negative), backs reads with its own word memory.
  always @(negedge sys_clk) begin
    if (mem_ready) begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      vcnt = 0;
    end else if (mem_valid) begin
      if (vcnt == 0) begin
        cur = '{mem_addr, mem_wdata, mem_wstrb};
        busq.push_back(cur);
      end else if ({mem_addr, mem_wdata, mem_wstrb} != cur) begin
        stab_err++;
      end
      vcnt++;
      last_len = vcnt;
      if (ack_delay >= 0 && vcnt == ack_delay + 1) begin
        mem_ready = 1'b1;
        if (mem_wstrb == 4'hF) dev_mem[mem_addr[31:2]] = mem_wdata;
        mem_rdata = dev_mem.exists(mem_addr[31:2]) ?
                    dev_mem[mem_addr[31:2]] : dflt(mem_addr[31:2]);
      end
    end else begin
      vcnt = 0;
    end
  end

  // UART tx sink: stalls tx_stall cycles per byte.
  always @(negedge sys_clk) begin
    if (tx_ready) begin
      tx_ready = 1'b0;
      scnt = 0;
    end else if (tx_valid) begin
      if (scnt == 0) tcap = tx_data;
      else if (tx_data != tcap) stab_err++;
      if (scnt >= tx_stall) begin
        tx_ready = 1'b1;
        txq.push_back(tx_data);
      end else begin
        scnt++;
      end
    end else begin
      scnt = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge sys_clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge sys_clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge sys_clk);
      if (!cpu_hold && !mem_valid && !tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic cmd(input logic [7:0] op, input bit has_a,
                     input logic [31:0] a, input bit has_d,
                     input logic [31:0] d);
    send(op);
    chk("hold_rise", 32'(cpu_hold), 32'd1);
    if (has_a) send_word(a);
    if (has_d) send_word(d);
    chk("valid_latency", 32'(mem_valid), 32'd1);
    wait_idle("cmd_done");
  endtask

  // One full transaction checked against the word-memory model.
  task automatic xact(input bit wr, input bit inc,
                      input logic [31:0] a, input logic [31:0] d,
                      input bit ok);
    logic [31:0] ea;
    logic [31:0] ed;
    logic [7:0]  op;
    ea = inc ? ptr : {a[31:2], 2'b00};
    op = wr ? (inc ? 8'h77 : 8'h57) : (inc ? 8'h72 : 8'h52);
    ed = ref_mem.exists(ea[31:2]) ? ref_mem[ea[31:2]] : dflt(ea[31:2]);
    busq.delete();
    txq.delete();
    cmd(op, !inc, a, wr, d);
    chk("bus_count", busq.size(), 32'd1);
    if (busq.size() == 1) begin
      chk("bus_addr", busq[0].a, ea);
      chk("bus_strb", 32'(busq[0].s), wr ? 32'hF : 32'h0);
      if (wr) chk("bus_wdata", busq[0].d, d);
    end
    if (!ok) begin
      chk("timeout_len", last_len, BUS_TO);
      chk("err_len", txq.size(), 32'd1);
      if (txq.size() == 1) chk("err_byte", 32'(txq[0]), 32'h45);
      ptr = ea;
    end else begin
      if (wr) begin
        chk("ack_len", txq.size(), 32'd1);
        if (txq.size() == 1) chk("ack_byte", 32'(txq[0]), 32'h4B);
        ref_mem[ea[31:2]] = d;
      end else begin
        chk("rd_len", txq.size(), 32'd4);
        if (txq.size() == 4)
          for (int i = 0; i < 4; i++)
            chk("rd_byte", 32'(txq[i]), 32'(ed[(3-i)*8 +: 8]));
      end
      ptr = ea + 32'd4;
    end
    chk("hold_fall", 32'(cpu_hold), 32'd0);
  endtask

  initial begin
    bit          flag;
    bit          wr;
    bit          ok;
    bit          inc;
    logic [31:0] a;
    logic [7:0]  b;

    repeat (3) @(negedge sys_clk);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_overrun", 32'(rx_overrun), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_strb", 32'(mem_wstrb), 32'd0);
    sys_resetn = 1'b1;

    // Directed write, ack two cycles late.
    ack_delay = 2;
    tx_stall  = 0;
    xact(1'b1, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 1'b1);
    chk("ack_after_2", last_len, 32'd3);

    // Directed read, slow transmitter.
    dev_mem[30'h2001] = 32'h0000_00A5;
    ref_mem[30'h2001] = 32'h0000_00A5;
    tx_stall = 3;
    xact(1'b0, 1'b0, 32'h0000_8004, 32'h0, 1'b1);

    // Bus timeouts, read then write.
    ack_delay = -1;
    tx_stall  = 1;
    xact(1'b0, 1'b0, 32'h0000_9000, 32'h0, 1'b0);
    xact(1'b1, 1'b0, 32'h0000_9008, 32'h1234_5678, 1'b0);

    // Parser timeout after a partial command.
    ack_delay = 1;
    busq.delete();
    txq.delete();
    send(8'h57);
    send(8'h00);
    send(8'h00);
    flag = 1'b0;
    for (int i = 0; i < 95; i++) begin
      @(negedge sys_clk);
      if (mem_valid) flag = 1'b1;
    end
    chk("pto_hold_early", 32'(cpu_hold), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      if (mem_valid) flag = 1'b1;
    end
    chk("pto_hold_late", 32'(cpu_hold), 32'd0);
    chk("pto_no_bus", 32'(flag), 32'd0);
    chk("pto_no_tx", txq.size(), 32'd0);
    xact(1'b0, 1'b0, 32'h0000_8004, 32'h0, 1'b1);

    // Misaligned read with a byte injected during the response.
    busq.delete();
    txq.delete();
    tx_stall = 6;
    send(8'h52);
    send_word(32'h0000_0107);
    flag = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (tx_valid) begin
        flag = 1'b1;
        break;
      end
    end
    chk("ovr_resp_seen", 32'(flag), 32'd1);
    chk("ovr_before", 32'(rx_overrun), 32'd0);
    send(8'h57);
    chk("ovr_set", 32'(rx_overrun), 32'd1);
    wait_idle("ovr_idle");
    chk("ovr_bus_count", busq.size(), 32'd1);
    if (busq.size() == 1) chk("misalign_addr", busq[0].a, 32'h0000_0104);
    chk("ovr_rsp_len", txq.size(), 32'd4);
    if (txq.size() == 4) begin
      chk("ovr_b0", 32'(txq[0]), 32'hDE);
      chk("ovr_b1", 32'(txq[1]), 32'hAD);
      chk("ovr_b2", 32'(txq[2]), 32'hBE);
      chk("ovr_b3", 32'(txq[3]), 32'hEF);
    end
    repeat (3) @(negedge sys_clk);
    chk("ovr_dropped", 32'(cpu_hold), 32'd0);
    chk("ovr_sticky", 32'(rx_overrun), 32'd1);

    tx_stall = 1;
`ifdef DBG_AUTOINC_EN
    xact(1'b1, 1'b0, 32'h0000_0FFC, 32'hCAFE_0001, 1'b1);
    xact(1'b1, 1'b1, 32'h0, 32'h1122_3344, 1'b1);
    xact(1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
    ack_delay = -1;
    xact(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    ack_delay = 1;
    xact(1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
    xact(1'b1, 1'b0, 32'hFFFF_FFFC, 32'hA1B2_C3D4, 1'b1);
    xact(1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
`else
    busq.delete();
    txq.delete();
    send(8'h77);
    send(8'h72);
    repeat (3) @(negedge sys_clk);
    chk("short_ignored_hold", 32'(cpu_hold), 32'd0);
    chk("short_ignored_bus", busq.size(), 32'd0);
    chk("short_ignored_tx", txq.size(), 32'd0);
`endif

    // Randomized traffic over a small word window.
    for (int n = 0; n < 24; n++) begin
      a = 32'h0000_2000 + 32'($urandom_range(0, 7) << 2)
          + 32'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      ok = ($urandom_range(0, 7) != 0);
      inc = AUTOINC && ($urandom_range(0, 1) == 1);
      ack_delay = ok ? int'($urandom_range(0, 3)) : -1;
      tx_stall = int'($urandom_range(0, 3));
      xact(wr, inc, a, $urandom, ok);
      if ($urandom_range(0, 1) == 1) begin
        b = 8'($urandom);
        if (b == 8'h57 || b == 8'h52 || b == 8'h77 || b == 8'h72)
          b = 8'h00;
        txq.delete();
        send(b);
        repeat (2) @(negedge sys_clk);
        chk("junk_ignored", 32'(cpu_hold), 32'd0);
        chk("junk_no_tx", txq.size(), 32'd0);
      end
    end

    // Reset in the middle of a stalled bus cycle.
    busq.delete();
    txq.delete();
    ack_delay = -1;
    send(8'h52);
    send_word(32'h0000_3000);
    repeat (3) @(negedge sys_clk);
    chk("mid_valid_high", 32'(mem_valid), 32'd1);
    sys_resetn = 1'b0;
    #1;
    chk("mid_valid_drop", 32'(mem_valid), 32'd0);
    chk("mid_hold_drop", 32'(cpu_hold), 32'd0);
    chk("mid_ovr_clear", 32'(rx_overrun), 32'd0);
    chk("mid_tx_drop", 32'(tx_valid), 32'd0);
    @(negedge sys_clk);
    sys_resetn = 1'b1;
    ptr = 32'h0;
    ack_delay = 0;
    tx_stall = 0;
    xact(1'b0, 1'b0, 32'h0000_0104, 32'h0, 1'b1);

    chk("stability", stab_err, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
